// File: rtl/mult_acc_if.sv
// Product/result bus between the multiplier side and mult_acc_collector.
// master: the producer/consumer environment; slave: the collector.
interface mult_acc_if #(
  parameter int N         = 5,
  parameter int ACC_W     = 2*N+4,
  parameter int BLOCK_LEN = 4
);
  localparam int CW = $clog2(BLOCK_LEN+1);

  logic [N-1:0]     m;
  logic [N-1:0]     r;
  logic             valid;
  logic             clear;
  logic [ACC_W-1:0] acc_out;
  logic [CW-1:0]    acc_count;
  logic             out_valid;
  logic             out_ready;
  logic             overflow;
  logic             drop;

  modport master (
    output m, r, valid, clear, out_ready,
    input  acc_out, acc_count, out_valid, overflow, drop
  );

  modport slave (
    input  m, r, valid, clear, out_ready,
    output acc_out, acc_count, out_valid, overflow, drop
  );
endinterface

// File: rtl/mult_acc_collector.sv
// Accumulates signed 2N-bit products {m, r} from a sequential multiplier and
// presents each BLOCK_LEN-product sum on a valid/ready handshake.
// Optional MULT_ACC_SAT_EN: clamp the accumulator on signed overflow instead
// of wrapping; the overflow flag is set in both builds.
//
// state | meaning
// ACCUM | collecting products of the current block
// HOLD  | block sum presented on acc_out, waiting for out_ready
module mult_acc_collector #(
  parameter int N         = 5,
  parameter int ACC_W     = 2*N+4,
  parameter int BLOCK_LEN = 4
) (
  input  logic        clk,
  input  logic        rst,
  mult_acc_if.slave   bus
);
  localparam int CW = $clog2(BLOCK_LEN+1);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] acc_out_q, acc_out_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    out_valid_q, out_valid_d;
  logic                    overflow_q, overflow_d;
  logic                    drop_q, drop_d;

  logic signed [2*N-1:0]   prod;
  logic signed [ACC_W-1:0] p_ext;
  logic signed [ACC_W-1:0] acc_base;
  logic signed [ACC_W-1:0] sum_raw;
  logic signed [ACC_W-1:0] sum_fin;
  logic [CW-1:0]           cnt_base;
  logic [CW-1:0]           cnt_inc;
  logic                    ovf_base;
  logic                    ovf_now;
  logic                    fresh;
  logic                    accept;

  // r carries raw low bits; the sign lives in the top bit of m
  assign prod  = {bus.m, bus.r};
  assign p_ext = ACC_W'(prod);

  // Handshake in HOLD starts a new block, so a same-cycle product adds to zero
  assign fresh    = (state_q == HOLD) && bus.out_ready;
  assign accept   = bus.valid && ((state_q == ACCUM) || bus.out_ready);
  assign acc_base = fresh ? '0 : acc_q;
  assign cnt_base = fresh ? '0 : cnt_q;
  assign ovf_base = fresh ? 1'b0 : overflow_q;
  assign sum_raw  = acc_base + p_ext;
  assign ovf_now  = (acc_base[ACC_W-1] == p_ext[ACC_W-1]) &&
                    (sum_raw[ACC_W-1] != acc_base[ACC_W-1]);
  assign cnt_inc  = cnt_base + CW'(1);

  // Overflow result: clamp toward the operands' sign, or keep the wrapped sum
`ifdef MULT_ACC_SAT_EN
  assign sum_fin = ovf_now ? (acc_base[ACC_W-1] ? ACC_MIN : ACC_MAX) : sum_raw;
`else
  assign sum_fin = sum_raw;
`endif

  // Next-state logic: clear overrides handshake, accept and drop
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    acc_out_d   = acc_out_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    overflow_d  = overflow_q;
    drop_d      = 1'b0;

    if (bus.clear) begin
      state_d     = ACCUM;
      acc_d       = '0;
      cnt_d       = '0;
      overflow_d  = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      if (fresh) begin
        state_d     = ACCUM;
        out_valid_d = 1'b0;
        acc_d       = '0;
        cnt_d       = '0;
        overflow_d  = 1'b0;
      end
      if (accept) begin
        acc_d      = sum_fin;
        cnt_d      = cnt_inc;
        overflow_d = ovf_base | ovf_now;
        if (cnt_inc == CW'(BLOCK_LEN)) begin
          state_d     = HOLD;
          acc_out_d   = sum_fin;
          out_valid_d = 1'b1;
        end
      end
      if ((state_q == HOLD) && !bus.out_ready && bus.valid) begin
        drop_d = 1'b1;
      end
    end
  end

  // State and registered outputs, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      acc_out_q   <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      acc_out_q   <= acc_out_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      drop_q      <= drop_d;
    end
  end

  assign bus.acc_out   = acc_out_q;
  assign bus.acc_count = cnt_q;
  assign bus.out_valid = out_valid_q;
  assign bus.overflow  = overflow_q;
  assign bus.drop      = drop_q;
endmodule

// File: tb/tb_mult_acc_collector.sv
// Directed bench for mult_acc_collector: default instance (N=5, ACC_W=14,
// BLOCK_LEN=4) plus a narrow instance (ACC_W=10, BLOCK_LEN=2) for overflow.
module tb_mult_acc_collector;
  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  mult_acc_if #(.N(5), .ACC_W(14), .BLOCK_LEN(4)) if0 ();
  mult_acc_if #(.N(5), .ACC_W(10), .BLOCK_LEN(2)) if1 ();

  mult_acc_collector #(.N(5), .ACC_W(14), .BLOCK_LEN(4)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0.slave)
  );

  mult_acc_collector #(.N(5), .ACC_W(10), .BLOCK_LEN(2)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // one product on if0 for one cycle
  task automatic pulse0(input logic [4:0] mv, input logic [4:0] rv);
    if0.m = mv; if0.r = rv; if0.valid = 1'b1;
    tick();
    if0.valid = 1'b0;
  endtask

  task automatic pulse1(input logic [4:0] mv, input logic [4:0] rv);
    if1.m = mv; if1.r = rv; if1.valid = 1'b1;
    tick();
    if1.valid = 1'b0;
  endtask

  task automatic handshake0();
    if0.out_ready = 1'b1;
    tick();
    if0.out_ready = 1'b0;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    rst = 1'b0;
    if0.m = '0; if0.r = '0; if0.valid = 1'b0; if0.clear = 1'b0; if0.out_ready = 1'b0;
    if1.m = '0; if1.r = '0; if1.valid = 1'b0; if1.clear = 1'b0; if1.out_ready = 1'b0;
    tick();
    rst = 1'b1;

    // reset state
    chk("rst_acc_out",   $signed(if0.acc_out), 0);
    chk("rst_acc_count", if0.acc_count, 0);
    chk("rst_out_valid", if0.out_valid, 0);
    chk("rst_overflow",  if0.overflow, 0);
    chk("rst_drop",      if0.drop, 0);

    // block of four -42 products
    pulse0(5'b11110, 5'b10110);
    pulse0(5'b11110, 5'b10110);
    pulse0(5'b11110, 5'b10110);
    chk("blk1_count3",  if0.acc_count, 3);
    chk("blk1_valid3",  if0.out_valid, 0);
    pulse0(5'b11110, 5'b10110);
    chk("blk1_valid",   if0.out_valid, 1);
    chk("blk1_acc_out", $signed(if0.acc_out), -168);
    chk("blk1_count",   if0.acc_count, 4);
    chk("blk1_ovf",     if0.overflow, 0);

    // product while holding is dropped
    pulse0(5'b00001, 5'b00000);
    chk("hold_drop",    if0.drop, 1);
    chk("hold_acc_out", $signed(if0.acc_out), -168);
    chk("hold_count",   if0.acc_count, 4);
    chk("hold_valid",   if0.out_valid, 1);
    tick();
    chk("hold_drop_end", if0.drop, 0);
    handshake0();
    chk("hs_valid", if0.out_valid, 0);
    chk("hs_count", if0.acc_count, 0);

    // handshake together with a +15 product
    repeat (4) pulse0(5'b11110, 5'b10110);
    chk("blk2_valid", if0.out_valid, 1);
    if0.out_ready = 1'b1;
    pulse0(5'b00000, 5'b01111);
    if0.out_ready = 1'b0;
    chk("hsv_valid", if0.out_valid, 0);
    chk("hsv_count", if0.acc_count, 1);
    chk("hsv_drop",  if0.drop, 0);
    repeat (3) pulse0(5'b00000, 5'b00000);
    chk("blk3_valid",   if0.out_valid, 1);
    chk("blk3_acc_out", $signed(if0.acc_out), 15);
    handshake0();

    // overflow on the narrow instance: 256 + 256 in 10 bits
    pulse1(5'b01000, 5'b00000);
    chk("ovf_first", if1.overflow, 0);
    pulse1(5'b01000, 5'b00000);
    chk("ovf_valid", if1.out_valid, 1);
    chk("ovf_flag",  if1.overflow, 1);
`ifdef MULT_ACC_SAT_EN
    chk("ovf_acc_out", $signed(if1.acc_out), 511);
`else
    chk("ovf_acc_out", $signed(if1.acc_out), -512);
`endif
    if1.out_ready = 1'b1;
    tick();
    if1.out_ready = 1'b0;
    chk("ovf_cleared", if1.overflow, 0);
    chk("ovf_hs_valid", if1.out_valid, 0);

    // clear with a simultaneous product
    pulse0(5'b11110, 5'b10110);
    pulse0(5'b11110, 5'b10110);
    chk("clr_pre_count", if0.acc_count, 2);
    if0.clear = 1'b1;
    pulse0(5'b00001, 5'b00000);
    if0.clear = 1'b0;
    chk("clr_count", if0.acc_count, 0);
    chk("clr_drop",  if0.drop, 0);
    chk("clr_valid", if0.out_valid, 0);
    repeat (4) pulse0(5'b11110, 5'b10110);
    chk("clr_blk_valid",   if0.out_valid, 1);
    chk("clr_blk_acc_out", $signed(if0.acc_out), -168);

    // reset while holding
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("hrst_acc_out", $signed(if0.acc_out), 0);
    chk("hrst_count",   if0.acc_count, 0);
    chk("hrst_valid",   if0.out_valid, 0);
    chk("hrst_ovf",     if0.overflow, 0);
    chk("hrst_drop",    if0.drop, 0);
    pulse0(5'b11110, 5'b10110);
    chk("hrst_next_count", if0.acc_count, 1);
    chk("hrst_next_valid", if0.out_valid, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/mult_acc_collector.md
Name: mult_acc_collector

Overview:
- Downstream consumer of the sequential signed multiplier (seqMult).
- Captures each 2N-bit product presented as {m, r} on the multiplier's valid pulse, sign-extends it and accumulates it.
- After BLOCK_LEN products, presents the block sum on a valid/ready output handshake.
- Used for dot-product style reductions over multiplier results.

Parameters:
- N, 5, multiplier operand width; product is 2N bits, {m, r}.
- ACC_W, 2*N+4, accumulator width; must be >= 2*N.
- BLOCK_LEN, 4, products per block; must be >= 1.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- m  in  N  product high half (signed) from multiplier.
- r  in  N  product low half from multiplier; treated as raw low bits, not signed.
- valid  in  1  single-cycle product-ready pulse from multiplier.
- clear  in  1  synchronous block abort; discards partial sum.
- acc_out  out  ACC_W  block sum (signed); stable while out_valid=1.
- acc_count  out  $clog2(BLOCK_LEN+1)  products accumulated in current block.
- out_valid  out  1  block sum available.
- out_ready  in  1  downstream accepts block sum.
- overflow  out  1  sticky; accumulation exceeded ACC_W signed range in this block.
- drop  out  1  one-cycle pulse; a product arrived while holding and was discarded.

Behaviour:
- Reset (rst=0 at clock edge) has priority over everything, including mid-block and mid-hold.
- Reset values:
  - acc_out=0, acc_count=0, out_valid=0, overflow=0, drop=0.
  - Internal accumulator=0; state=ACCUM.
- Product value: P = sign-extend of the 2N-bit concatenation {m, r} to ACC_W.
  - Example, N=5: m=11110, r=10110 gives P=-42.
- ACCUM state:
  - On valid=1: acc <= acc + P and acc_count <= acc_count + 1.
  - When this accept makes acc_count equal BLOCK_LEN: go to HOLD, acc_out <= the new sum, out_valid <= 1 on the same edge.
  - Latency: out_valid is high in the cycle after the BLOCK_LEN-th valid pulse.
- HOLD state:
  - out_valid stays 1 and acc_out stays constant until out_ready=1.
  - valid=1 with out_ready=0: product discarded, drop=1 for one cycle, no other state change.
  - out_ready=1 (handshake): out_valid <= 0, accumulator, acc_count and overflow cleared, go to ACCUM.
  - Handshake plus valid in the same cycle: the product is accepted as the first product of the new block (acc=P, acc_count=1), no drop.
- clear=1 (rst=1): in any state, acc=0, acc_count=0, overflow=0, out_valid=0, state=ACCUM.
  - clear has priority over valid and out_ready; a simultaneous product is discarded and drop stays 0.
- Overflow detection: signed overflow of acc + P (operand signs equal, result sign differs) sets overflow=1, sticky until handshake, clear or reset.
- drop is 0 in every cycle not described above.
- valid is a single-cycle pulse; a valid held high for k cycles counts as k products.

Optional Feature:
- Macro: MULT_ACC_SAT_EN.
- Defined: on overflow the accumulator clamps to the signed range limit in the overflow direction, 2^(ACC_W-1)-1 or -2^(ACC_W-1); overflow still flags.
- Not defined: two's-complement wrap-around; overflow still flags.

Test Plan:
- Defaults, rst low 1 cycle, four valid pulses with m=11110, r=10110 (-42) -> out_valid=1 one cycle after 4th pulse, acc_out=-168, acc_count=4, overflow=0.
- Hold out_ready=0 after block complete, pulse valid with m=00001, r=00000 -> drop=1 one cycle, acc_out stays -168; then out_ready=1 -> out_valid=0, acc_count=0.
- out_ready=1 and valid (P=+15: m=00000, r=01111) in same cycle -> handshake completes, no drop, acc_count=1, next block sum starts at 15.
- ACC_W=10, two products of +256 (m=01000, r=00000): without macro -> acc_out=-512, overflow=1; with MULT_ACC_SAT_EN -> acc_out=511, overflow=1.
- Two products accumulated, then clear=1 together with a valid pulse -> acc_count=0, drop=0; next four products of -42 -> acc_out=-168.
- rst low during HOLD with out_valid=1 -> next cycle all outputs 0, state ACCUM; next valid gives acc_count=1.
